// File: rtl/read_data_router.sv
// Routes AXI read-data beats from three slaves back to two masters; round-robin slave arbitration.
// Latency: one IDLE cycle to arbitrate, then beats pass combinationally slave -> master.
// Backpressure: the targeted master's ready drives the granted slave's ready; unmapped IDs are sunk (ready = 1).
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   RID/RDATA/RRESP/RLAST/RVALID_S0..S2 (in), RREADY_S0..S2 (out)   slave-side read channel
//   RID/RDATA/RRESP/RLAST/RVALID_M0..M1 (out), RREADY_M0..M1 (in)   master-side read channel
//   RID_Sx[7:4] selects the master, RID_Sx[3:0] is the ID returned to that master.
module read_data_router #(
    parameter int RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [7:0]  RID_S0,
    input  logic [31:0] RDATA_S0,
    input  logic [1:0]  RRESP_S0,
    input  logic        RLAST_S0,
    input  logic        RVALID_S0,
    output logic        RREADY_S0,

    input  logic [7:0]  RID_S1,
    input  logic [31:0] RDATA_S1,
    input  logic [1:0]  RRESP_S1,
    input  logic        RLAST_S1,
    input  logic        RVALID_S1,
    output logic        RREADY_S1,

    input  logic [7:0]  RID_S2,
    input  logic [31:0] RDATA_S2,
    input  logic [1:0]  RRESP_S2,
    input  logic        RLAST_S2,
    input  logic        RVALID_S2,
    output logic        RREADY_S2,

    output logic [3:0]  RID_M0,
    output logic [31:0] RDATA_M0,
    output logic [1:0]  RRESP_M0,
    output logic        RLAST_M0,
    output logic        RVALID_M0,
    input  logic        RREADY_M0,

    output logic [3:0]  RID_M1,
    output logic [31:0] RDATA_M1,
    output logic [1:0]  RRESP_M1,
    output logic        RLAST_M1,
    output logic        RVALID_M1,
    input  logic        RREADY_M1
);

    localparam logic [1:0] RR_INIT_P = RR_INIT[1:0];

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] g, g_nxt;
    logic [1:0] p, p_nxt;

    // Bit 3 is a permanent zero so a 2-bit index can never fall off the vector.
    logic [3:0] req;
    assign req = {1'b0, RVALID_S2, RVALID_S1, RVALID_S0};

    logic [7:0]  sel_rid;
    logic [31:0] sel_data;
    logic [1:0]  sel_resp;
    logic        sel_last;
    logic        sel_vld;
    logic [3:0]  tgt;
    logic        rdy_sel;
    logic [2:0]  rdy_s;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v >= 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // First requester scanning p, p+1, p+2 (mod 3).
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] c0, c1, c2;
        c0 = ptr;
        c1 = inc3(c0);
        c2 = inc3(c1);
        if (r[c0])
            return c0;
        else if (r[c1])
            return c1;
        else
            return c2;
    endfunction

    // Granted-slave mux.
    always_comb begin
        sel_rid  = '0;
        sel_data = '0;
        sel_resp = '0;
        sel_last = 1'b0;
        sel_vld  = 1'b0;
        case (g)
            2'd0: begin
                sel_rid  = RID_S0;
                sel_data = RDATA_S0;
                sel_resp = RRESP_S0;
                sel_last = RLAST_S0;
                sel_vld  = RVALID_S0;
            end
            2'd1: begin
                sel_rid  = RID_S1;
                sel_data = RDATA_S1;
                sel_resp = RRESP_S1;
                sel_last = RLAST_S1;
                sel_vld  = RVALID_S1;
            end
            2'd2: begin
                sel_rid  = RID_S2;
                sel_data = RDATA_S2;
                sel_resp = RRESP_S2;
                sel_last = RLAST_S2;
                sel_vld  = RVALID_S2;
            end
            default: begin
                sel_rid  = '0;
            end
        endcase
    end

    // Output routing and next-state logic.
    always_comb begin
        RID_M0    = '0;
        RDATA_M0  = '0;
        RRESP_M0  = '0;
        RLAST_M0  = 1'b0;
        RVALID_M0 = 1'b0;
        RID_M1    = '0;
        RDATA_M1  = '0;
        RRESP_M1  = '0;
        RLAST_M1  = 1'b0;
        RVALID_M1 = 1'b0;
        rdy_sel   = 1'b0;
        rdy_s     = '0;
        tgt       = sel_rid[7:4];
        state_nxt = state;
        g_nxt     = g;
        p_nxt     = p;

        // Outputs are forced low while reset is held, even mid-burst.
        if (!rst && state == BUSY) begin
            if (tgt == 4'd0) begin
                RVALID_M0 = sel_vld;
                RID_M0    = sel_rid[3:0];
                RDATA_M0  = sel_data;
                RRESP_M0  = sel_resp;
                RLAST_M0  = sel_last;
                rdy_sel   = RREADY_M0;
            end else if (tgt == 4'd1) begin
                RVALID_M1 = sel_vld;
                RID_M1    = sel_rid[3:0];
                RDATA_M1  = sel_data;
                RRESP_M1  = sel_resp;
                RLAST_M1  = sel_last;
                rdy_sel   = RREADY_M1;
            end else begin
                // No such master: drain the burst so the slave is not wedged.
                rdy_sel   = 1'b1;
            end
            case (g)
                2'd0:    rdy_s[0] = rdy_sel;
                2'd1:    rdy_s[1] = rdy_sel;
                2'd2:    rdy_s[2] = rdy_sel;
                default: rdy_s    = '0;
            endcase
        end

        case (state)
            IDLE: begin
                if (|req) begin
                    g_nxt     = pick(req, p);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (sel_vld && rdy_sel && sel_last) begin
                    state_nxt = IDLE;
                    p_nxt     = inc3(g);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign RREADY_S0 = rdy_s[0];
    assign RREADY_S1 = rdy_s[1];
    assign RREADY_S2 = rdy_s[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            g     <= 2'd0;
            p     <= RR_INIT_P;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            p     <= p_nxt;
        end
    end

endmodule

// File: tb/tb_read_data_router.sv
// Bench for read_data_router: queue-based slaves, transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed beat/grant orders.
module tb_read_data_router;

    localparam int RR_INIT = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0]  rid_s  [3];
    logic [31:0] dat_s  [3];
    logic [1:0]  resp_s [3];
    logic        last_s [3];
    logic        vld_s  [3];
    logic        rdy_s  [3];

    logic [3:0]  id_m   [2];
    logic [31:0] dat_m  [2];
    logic [1:0]  resp_m [2];
    logic        last_m [2];
    logic        vld_m  [2];
    logic        rdy_m  [2];

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       sq    [3][$];
    int unsigned m_log [2][$];
    int unsigned g_log [$];
    int          sink_cnt;

    // Reference model: which slave owns the return path (-1 = none) and the next-priority slave.
    int m_owner;
    int m_ptr;

    int checks;
    int errors;

    always #5 clk = ~clk;

    read_data_router #(.RR_INIT(RR_INIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .RID_S0    (rid_s[0]),  .RDATA_S0 (dat_s[0]), .RRESP_S0 (resp_s[0]),
        .RLAST_S0  (last_s[0]), .RVALID_S0(vld_s[0]), .RREADY_S0(rdy_s[0]),
        .RID_S1    (rid_s[1]),  .RDATA_S1 (dat_s[1]), .RRESP_S1 (resp_s[1]),
        .RLAST_S1  (last_s[1]), .RVALID_S1(vld_s[1]), .RREADY_S1(rdy_s[1]),
        .RID_S2    (rid_s[2]),  .RDATA_S2 (dat_s[2]), .RRESP_S2 (resp_s[2]),
        .RLAST_S2  (last_s[2]), .RVALID_S2(vld_s[2]), .RREADY_S2(rdy_s[2]),
        .RID_M0    (id_m[0]),   .RDATA_M0 (dat_m[0]), .RRESP_M0 (resp_m[0]),
        .RLAST_M0  (last_m[0]), .RVALID_M0(vld_m[0]), .RREADY_M0(rdy_m[0]),
        .RID_M1    (id_m[1]),   .RDATA_M1 (dat_m[1]), .RRESP_M1 (resp_m[1]),
        .RLAST_M1  (last_m[1]), .RVALID_M1(vld_m[1]), .RREADY_M1(rdy_m[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_q(input string nm, input int unsigned got[$], input int unsigned exp[$]);
        chk({nm, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < got.size())
                chk($sformatf("%s_%0d", nm, i), 64'(got[i]), 64'(exp[i]));
    endtask

    task automatic drive_slaves();
        for (int s = 0; s < 3; s++) begin
            if (sq[s].size() > 0) begin
                vld_s[s]  = 1'b1;
                rid_s[s]  = sq[s][0].id;
                dat_s[s]  = sq[s][0].data;
                resp_s[s] = sq[s][0].resp;
                last_s[s] = sq[s][0].last;
            end else begin
                vld_s[s]  = 1'b0;
                rid_s[s]  = '0;
                dat_s[s]  = '0;
                resp_s[s] = '0;
                last_s[s] = 1'b0;
            end
        end
    endtask

    task automatic clear_logs();
        m_log[0].delete();
        m_log[1].delete();
        g_log.delete();
        sink_cnt = 0;
    endtask

    // One clock: compare at negedge against the model, then advance model and slaves past posedge.
    task automatic step();
        logic        e_rdy_s [3];
        logic        e_vld_m [2];
        logic [3:0]  e_id_m  [2];
        logic [31:0] e_dat_m [2];
        logic [1:0]  e_resp_m[2];
        logic        e_last_m[2];
        logic        hs_s    [3];
        int nxt_owner, nxt_ptr, o, t;

        @(negedge clk);
        for (int s = 0; s < 3; s++) e_rdy_s[s] = 1'b0;
        for (int m = 0; m < 2; m++) begin
            e_vld_m[m] = 1'b0; e_id_m[m] = '0; e_dat_m[m] = '0; e_resp_m[m] = '0; e_last_m[m] = 1'b0;
        end
        nxt_owner = m_owner;
        nxt_ptr   = m_ptr;
        if (!rst) begin
            if (m_owner < 0) begin
                for (int k = 0; k < 3; k++) begin
                    o = (m_ptr + k) % 3;
                    if (vld_s[o] && nxt_owner < 0) nxt_owner = o;
                end
            end else begin
                o = m_owner;
                t = int'(rid_s[o][7:4]);
                if (t < 2) begin
                    e_vld_m[t]  = vld_s[o];
                    e_id_m[t]   = rid_s[o][3:0];
                    e_dat_m[t]  = dat_s[o];
                    e_resp_m[t] = resp_s[o];
                    e_last_m[t] = last_s[o];
                    e_rdy_s[o]  = rdy_m[t];
                end else begin
                    e_rdy_s[o]  = 1'b1;
                end
                if (vld_s[o] && e_rdy_s[o] && last_s[o]) begin
                    nxt_owner = -1;
                    nxt_ptr   = (o + 1) % 3;
                end
            end
        end

        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d_vld", m),  64'(vld_m[m]),  64'(e_vld_m[m]));
            chk($sformatf("m%0d_id", m),   64'(id_m[m]),   64'(e_id_m[m]));
            chk($sformatf("m%0d_data", m), 64'(dat_m[m]),  64'(e_dat_m[m]));
            chk($sformatf("m%0d_resp", m), 64'(resp_m[m]), 64'(e_resp_m[m]));
            chk($sformatf("m%0d_last", m), 64'(last_m[m]), 64'(e_last_m[m]));
            if (vld_m[m] && rdy_m[m]) m_log[m].push_back(dat_m[m]);
        end
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("s%0d_rdy", s), 64'(rdy_s[s]), 64'(e_rdy_s[s]));
            hs_s[s] = vld_s[s] && rdy_s[s];
            if (hs_s[s] && last_s[s]) g_log.push_back(s);
            if (hs_s[s] && !vld_m[0] && !vld_m[1]) sink_cnt++;
        end

        @(posedge clk);
        if (rst) begin
            m_owner = -1;
            m_ptr   = RR_INIT;
        end else begin
            m_owner = nxt_owner;
            m_ptr   = nxt_ptr;
        end
        #1;
        for (int s = 0; s < 3; s++)
            if (hs_s[s] && sq[s].size() > 0) void'(sq[s].pop_front());
        drive_slaves();
        #1;
    endtask

    task automatic wait_done(input int max, input string nm);
        int n;
        logic busy;
        n = 0;
        busy = (sq[0].size() + sq[1].size() + sq[2].size() > 0) || (m_owner >= 0);
        while (busy && n < max) begin
            step();
            n++;
            busy = (sq[0].size() + sq[1].size() + sq[2].size() > 0) || (m_owner >= 0);
        end
        chk({nm, "_drain_timeout"}, 64'(busy), 64'(0));
    endtask

    task automatic wait_beats(input int m, input int n, input int max, input string nm);
        int k;
        k = 0;
        while (m_log[m].size() < n && k < max) begin
            step();
            k++;
        end
        chk({nm, "_beat_timeout"}, 64'(m_log[m].size() < n), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned e[$];

        checks   = 0;
        errors   = 0;
        m_owner  = -1;
        m_ptr    = RR_INIT;
        sink_cnt = 0;
        rdy_m[0] = 1'b1;
        rdy_m[1] = 1'b1;
        drive_slaves();

        // Reset and idle state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("idle_vld_m0", 64'(vld_m[0]), 64'(0));
        chk("idle_vld_m1", 64'(vld_m[1]), 64'(0));
        chk("idle_rdy_s", 64'({rdy_s[0], rdy_s[1], rdy_s[2]}), 64'(0));

        // Single beat S1 -> M1
        clear_logs();
        sq[1].push_back(beat_t'{8'h13, 32'hDEADBEEF, 2'b00, 1'b1});
        drive_slaves();
        step();
        chk("single_vld_m1", 64'(vld_m[1]), 64'(1));
        chk("single_id_m1", 64'(id_m[1]), 64'h3);
        chk("single_rdy_s1", 64'(rdy_s[1]), 64'(1));
        chk("single_dat_m1", 64'(dat_m[1]), 64'hDEADBEEF);
        chk("single_vld_m0", 64'(vld_m[0]), 64'(0));
        step();
        chk("single_after_vld_m1", 64'(vld_m[1]), 64'(0));
        chk("single_model_ptr", 64'(m_ptr), 64'(2));
        e = '{32'hDEADBEEF};
        chk_q("single_m1_log", m_log[1], e);

        // 4-beat burst S0 -> M0, master stalls three cycles on beat 2
        clear_logs();
        for (int i = 0; i < 4; i++)
            sq[0].push_back(beat_t'{8'h0A, 32'(32'h100 + i), 2'b01, (i == 3)});
        drive_slaves();
        wait_beats(0, 1, 20, "burst");
        rdy_m[0] = 1'b0;
        repeat (3) begin
            step();
            chk("stall_rdy_s0", 64'(rdy_s[0]), 64'(0));
            chk("stall_vld_m0", 64'(vld_m[0]), 64'(1));
            chk("stall_dat_m0", 64'(dat_m[0]), 64'h101);
        end
        rdy_m[0] = 1'b1;
        wait_done(20, "burst");
        e = '{32'h100, 32'h101, 32'h102, 32'h103};
        chk_q("burst_m0_log", m_log[0], e);
        chk("burst_model_ptr", 64'(m_ptr), 64'(1));

        // Round-robin from reset, all three slaves requesting together
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_logs();
        sq[0].push_back(beat_t'{8'h01, 32'd200, 2'b00, 1'b1});
        sq[0].push_back(beat_t'{8'h02, 32'd201, 2'b00, 1'b1});
        sq[1].push_back(beat_t'{8'h13, 32'd300, 2'b00, 1'b1});
        sq[2].push_back(beat_t'{8'h14, 32'd400, 2'b10, 1'b1});
        drive_slaves();
        wait_done(40, "rr");
        e = '{0, 1, 2, 0};
        chk_q("rr_grant_order", g_log, e);
        e = '{32'd200, 32'd201};
        chk_q("rr_m0_log", m_log[0], e);
        e = '{32'd300, 32'd400};
        chk_q("rr_m1_log", m_log[1], e);

        // Unmapped master index: burst is sunk
        clear_logs();
        sq[2].push_back(beat_t'{8'h55, 32'd500, 2'b00, 1'b0});
        sq[2].push_back(beat_t'{8'h55, 32'd501, 2'b00, 1'b1});
        drive_slaves();
        wait_done(20, "unmapped");
        chk("unmapped_sunk", 64'(sink_cnt), 64'(2));
        chk("unmapped_m0_beats", 64'(m_log[0].size()), 64'(0));
        chk("unmapped_m1_beats", 64'(m_log[1].size()), 64'(0));
        e = '{2};
        chk_q("unmapped_grant", g_log, e);

        // Contention: S2 arrives while S0 bursts to M0
        clear_logs();
        for (int i = 0; i < 3; i++)
            sq[0].push_back(beat_t'{8'h07, 32'(32'd600 + i), 2'b00, (i == 2)});
        drive_slaves();
        step();
        sq[2].push_back(beat_t'{8'h1C, 32'd700, 2'b00, 1'b1});
        drive_slaves();
        wait_done(30, "contention");
        e = '{0, 2};
        chk_q("contention_grant", g_log, e);
        e = '{32'd600, 32'd601, 32'd602};
        chk_q("contention_m0_log", m_log[0], e);
        e = '{32'd700};
        chk_q("contention_m1_log", m_log[1], e);

        // Move the pointer away from RR_INIT, then reset in the middle of a burst
        clear_logs();
        sq[0].push_back(beat_t'{8'h03, 32'd800, 2'b00, 1'b1});
        drive_slaves();
        wait_done(10, "preset");
        chk("preset_model_ptr", 64'(m_ptr), 64'(1));
        clear_logs();
        for (int i = 0; i < 4; i++)
            sq[1].push_back(beat_t'{8'h02, 32'(32'd900 + i), 2'b00, (i == 3)});
        drive_slaves();
        wait_beats(0, 2, 20, "midrst");
        rst = 1'b1;
        sq[1].delete();
        drive_slaves();
        step();
        chk("midrst_vld_m0", 64'(vld_m[0]), 64'(0));
        chk("midrst_rdy_s1", 64'(rdy_s[1]), 64'(0));
        rst = 1'b0;
        step();
        chk("postrst_vld_m0", 64'(vld_m[0]), 64'(0));
        chk("postrst_model_ptr", 64'(m_ptr), 64'(RR_INIT));
        e = '{32'd900, 32'd901};
        chk_q("midrst_m0_log", m_log[0], e);
        clear_logs();
        sq[0].push_back(beat_t'{8'h04, 32'hA00, 2'b00, 1'b1});
        sq[1].push_back(beat_t'{8'h15, 32'hB00, 2'b00, 1'b1});
        sq[2].push_back(beat_t'{8'h06, 32'hC00, 2'b00, 1'b1});
        drive_slaves();
        wait_done(30, "postrst");
        e = '{0, 1, 2};
        chk_q("postrst_grant", g_log, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_data_router.md
READ_DATA_ROUTER -- requirements
Module: read_data_router

Interface
REQ-001 Parameter RR_INIT, default 0, meaning: slave index (0..2) holding highest arbitration priority after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 RID_Sx  input  `AXI_IDS_BITS (8)  per slave S0..S2; [7:4] = master index, [3:0] = master-side ID.
REQ-005 RDATA_Sx  input  `AXI_DATA_BITS (32)  per slave S0..S2.
REQ-006 RRESP_Sx  input  2  per slave S0..S2.
REQ-007 RLAST_Sx  input  1  per slave S0..S2.
REQ-008 RVALID_Sx  input  1  per slave S0..S2.
REQ-009 RREADY_Sx  output  1  per slave S0..S2.
REQ-010 RID_My  output  `AXI_ID_BITS (4)  per master M0, M1.
REQ-011 RDATA_My  output  32  per master M0, M1.
REQ-012 RRESP_My  output  2  per master M0, M1.
REQ-013 RLAST_My  output  1  per master M0, M1.
REQ-014 RVALID_My  output  1  per master M0, M1.
REQ-015 RREADY_My  input  1  per master M0, M1.

Function
REQ-016 FSM states: IDLE, BUSY; one registered grant index g (0..2); one registered round-robin pointer p (0..2).
REQ-017 IDLE: if any RVALID_Sx = 1, latch g = first requesting slave starting from p and searching p, p+1, p+2 (mod 3); go to BUSY next cycle.
REQ-018 IDLE: all RREADY_Sx = 0, all RVALID_My = 0; minimum latency from RVALID_Sx rise to RVALID_My rise is 1 cycle.
REQ-019 BUSY: target t = RID_Sg[7:4]; t = 0 selects M0, t = 1 selects M1; any other value is unmapped.
REQ-020 BUSY, mapped: RVALID_Mt = RVALID_Sg; RID_Mt = RID_Sg[3:0]; RDATA/RRESP/RLAST passed combinationally from Sg; RREADY_Sg = RREADY_Mt.
REQ-021 BUSY, unmapped: RREADY_Sg = 1 (beats sunk and discarded); both RVALID_My = 0.
REQ-022 Non-granted slaves: RREADY_Sx = 0 in all states. Non-targeted master: RVALID, RID, RDATA, RRESP, RLAST all 0.
REQ-023 BUSY exit: on RVALID_Sg & RREADY_Sg & RLAST_Sg, go to IDLE and set p = (g+1) mod 3 in the same edge.
REQ-024 Beat without RLAST stays in BUSY; bursts are never interleaved; g is held constant for the whole burst.
REQ-025 RVALID_Sg low during BUSY: no transfer; state, g, p unchanged.
REQ-026 Master stall (RREADY_Mt = 0): RREADY_Sg = 0; slave holds beat; no state change.
REQ-027 Only one slave is routed per cycle; two masters are never driven simultaneously.
REQ-028 Requests arriving during BUSY wait; they are arbitrated on the next IDLE cycle.
REQ-029 Pointer arithmetic: mod-3 wrap, so p = 2 and g = 2 gives next p = 0.

Reset
REQ-030 rst = 1 at any edge (including mid-burst): state = IDLE, g = 0, p = RR_INIT; outputs combinationally 0 while rst = 1.
REQ-031 A burst interrupted by reset is abandoned; no completion is generated.

Verification
REQ-032 Single beat: S1 RVALID = 1, RID = 8'h13, RLAST = 1, RDATA = 32'hDEADBEEF, M1 RREADY = 1 -> cycle+1: RVALID_M1 = 1, RID_M1 = 4'h3, RREADY_S1 = 1; IDLE next cycle; p = 2.
REQ-033 4-beat burst S0 -> M0 with M0 RREADY low on beat 2 for 3 cycles -> RREADY_S0 = 0 during stall; 4 beats delivered in order; BUSY held until RLAST.
REQ-034 Round-robin: S0, S1, S2 all request simultaneously from reset (RR_INIT = 0), single-beat each -> grant order S0, S1, S2; then S0 again.
REQ-035 Unmapped: S2 RID = 8'h55, 2-beat burst -> RREADY_S2 = 1 each beat; RVALID_M0 = RVALID_M1 = 0; returns to IDLE after RLAST.
REQ-036 Contention: S0 bursting to M0 while S2 requests M1 -> S2 waits (RREADY_S2 = 0) until S0 RLAST handshake, then granted 1 cycle later.
REQ-037 Reset mid-burst: rst = 1 after beat 2 of 4 -> next cycle IDLE, all outputs 0, p = RR_INIT; new request accepted normally.
